// File: rtl/mips_pipe_pkg.sv
// Shared widths and the operand-bypass select encoding for the MIPS pipeline.
package mips_pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CTRL_W = 16;
    localparam int REG_ZERO   = 0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Purpose: pick one source operand from EX/MEM/WB bypass candidates or register-file data.
// Latency: combinational.
// Backpressure: none; purely a function of its inputs.
module fwd_mux
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] src,
    input  logic              ex_fwd,
    input  logic [ADDR_W-1:0] ex_dst,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_wr,
    input  logic [ADDR_W-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] operand,
    output fwd_sel_e          sel
);

    always_comb begin
        sel     = FWD_RF;
        operand = rf_data;
        // $0 is hardwired: a stale write aimed at it must never leak through
        if (src == ADDR_W'(REG_ZERO)) begin
            operand = '0;
        end else if (ex_fwd && ex_dst == src) begin
            sel     = FWD_EX;
            operand = ex_data;
        end else if (mem_wr && mem_dst == src) begin
            sel     = FWD_MEM;
            operand = mem_data;
        end else if (wb_wr && wb_dst == src) begin
            sel     = FWD_WB;
            operand = wb_data;
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// Purpose: ID operand fetch with EX/MEM/WB bypass, load-use stall and the ID/EX register.
// Latency: one cycle ID->EX; a load-use hazard costs exactly one bubble.
// Backpressure: ex_hold freezes ID/EX and raises id_stall; load-use raises id_stall for one cycle.
module id_operand_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic              in_use_rs,
    input  logic              in_use_rt,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic              in_reg_wr,
    input  logic              in_mem_rd,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [ADDR_W-1:0] rf_addr1,
    output logic [ADDR_W-1:0] rf_addr2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_wr,
    input  logic [ADDR_W-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              id_stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_imm,
    output logic [ADDR_W-1:0] out_dst,
    output logic              out_reg_wr,
    output logic              out_mem_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [15:0]       stall_cnt
);

    logic [DATA_W-1:0] opnd_a, opnd_b;
    fwd_sel_e          sel_a, sel_b;
    logic              ex_fwd, lu;
    logic [3:0]        unused_sel;

    assign rf_addr1   = in_rs;
    assign rf_addr2   = in_rt;
    assign unused_sel = {sel_a, sel_b};

    // A load in EX has no data yet; it is handled by the stall, not the bypass
    assign ex_fwd = out_valid & out_reg_wr & ~out_mem_rd;

    fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
        .src(in_rs), .ex_fwd(ex_fwd), .ex_dst(out_dst), .ex_data(ex_result),
        .mem_wr(mem_wr), .mem_dst(mem_dst), .mem_data(mem_data),
        .wb_wr(wb_wr), .wb_dst(wb_dst), .wb_data(wb_data),
        .rf_data(rf_data1), .operand(opnd_a), .sel(sel_a)
    );

    fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
        .src(in_rt), .ex_fwd(ex_fwd), .ex_dst(out_dst), .ex_data(ex_result),
        .mem_wr(mem_wr), .mem_dst(mem_dst), .mem_data(mem_data),
        .wb_wr(wb_wr), .wb_dst(wb_dst), .wb_data(wb_data),
        .rf_data(rf_data2), .operand(opnd_b), .sel(sel_b)
    );

    assign lu = in_valid & out_valid & out_mem_rd & out_reg_wr &
                (out_dst != ADDR_W'(REG_ZERO)) &
                ((in_use_rs & (in_rs == out_dst)) | (in_use_rt & (in_rt == out_dst)));

    assign id_stall = ex_hold | (lu & ~flush);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_a      <= '0;
            out_b      <= '0;
            out_imm    <= '0;
            out_dst    <= '0;
            out_reg_wr <= 1'b0;
            out_mem_rd <= 1'b0;
            out_ctrl   <= '0;
            stall_cnt  <= '0;
        end else if (!ex_hold) begin
            if (flush || lu) begin
                out_valid  <= 1'b0;
                out_a      <= '0;
                out_b      <= '0;
                out_imm    <= '0;
                out_dst    <= '0;
                out_reg_wr <= 1'b0;
                out_mem_rd <= 1'b0;
                out_ctrl   <= '0;
            end else begin
                out_valid  <= in_valid;
                out_a      <= opnd_a;
                out_b      <= opnd_b;
                out_imm    <= in_imm;
                out_dst    <= in_dst;
                out_reg_wr <= in_valid & in_reg_wr;
                out_mem_rd <= in_valid & in_mem_rd;
                out_ctrl   <= in_ctrl;
            end
            if (!flush && lu && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Randomized scoreboard bench for id_operand_stage with a rule-level reference model.
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid, in_use_rs, in_use_rt, in_reg_wr, in_mem_rd;
    logic [4:0]  in_rs, in_rt, in_dst, rf_addr1, rf_addr2, mem_dst, wb_dst;
    logic [31:0] in_imm, rf_data1, rf_data2, ex_result, mem_data, wb_data;
    logic [15:0] in_ctrl, stall_cnt, out_ctrl;
    logic        mem_wr, wb_wr, flush, ex_hold, id_stall;
    logic        out_valid, out_reg_wr, out_mem_rd;
    logic [31:0] out_a, out_b, out_imm;
    logic [4:0]  out_dst;

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic        reg_wr;
        logic        mem_rd;
        logic [15:0] ctrl;
        logic [15:0] cnt;
    } st_t;

    st_t         m;
    st_t         oq[$];
    logic [10:0] sq[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    id_operand_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_rs(in_rs), .in_rt(in_rt),
        .in_use_rs(in_use_rs), .in_use_rt(in_use_rt), .in_dst(in_dst),
        .in_reg_wr(in_reg_wr), .in_mem_rd(in_mem_rd), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_result(ex_result),
        .mem_wr(mem_wr), .mem_dst(mem_dst), .mem_data(mem_data),
        .wb_wr(wb_wr), .wb_dst(wb_dst), .wb_data(wb_data),
        .flush(flush), .ex_hold(ex_hold), .id_stall(id_stall),
        .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
        .out_dst(out_dst), .out_reg_wr(out_reg_wr), .out_mem_rd(out_mem_rd),
        .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
    );

    task automatic cmp(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic st_t dut_state();
        return {out_valid, out_a, out_b, out_imm, out_dst, out_reg_wr, out_mem_rd, out_ctrl, stall_cnt};
    endfunction

    // Bypass rule: youngest writer wins, EX only for non-loads, $0 is always zero
    function automatic logic [31:0] ref_operand(input logic [4:0] s, input logic [31:0] rf);
        if (s == 5'd0) return 32'd0;
        if (m.valid && m.reg_wr && !m.mem_rd && m.dst == s) return ex_result;
        if (mem_wr && mem_dst == s) return mem_data;
        if (wb_wr && wb_dst == s) return wb_data;
        return rf;
    endfunction

    // Inputs are already driven; predict this cycle's stall and the next ID/EX contents
    task automatic step();
        logic lu, stall;
        st_t  nx;
        lu = in_valid && m.valid && m.mem_rd && m.reg_wr && m.dst != 5'd0 &&
             ((in_use_rs && in_rs == m.dst) || (in_use_rt && in_rt == m.dst));
        stall = ex_hold || (lu && !flush);
        sq.push_back({stall, in_rs, in_rt});
        nx = m;
        if (!ex_hold) begin
            if (flush || lu) begin
                nx = '0;
                nx.cnt = m.cnt;
                if (!flush && m.cnt < 16'hFFFF) nx.cnt = m.cnt + 16'd1;
            end else begin
                nx.valid  = in_valid;
                nx.a      = ref_operand(in_rs, rf_data1);
                nx.b      = ref_operand(in_rt, rf_data2);
                nx.imm    = in_imm;
                nx.dst    = in_dst;
                nx.reg_wr = in_valid && in_reg_wr;
                nx.mem_rd = in_valid && in_mem_rd;
                nx.ctrl   = in_ctrl;
            end
        end
        m = nx;
        oq.push_back(nx);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        in_valid = 0; in_rs = 0; in_rt = 0; in_use_rs = 0; in_use_rt = 0; in_dst = 0;
        in_reg_wr = 0; in_mem_rd = 0; in_imm = 0; in_ctrl = 0; rf_data1 = 0; rf_data2 = 0;
        ex_result = 0; mem_wr = 0; mem_dst = 0; mem_data = 0; wb_wr = 0; wb_dst = 0;
        wb_data = 0; flush = 0; ex_hold = 0;
    endtask

    task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                         input logic ld, input logic [31:0] imm);
        in_valid = 1; in_rs = rs; in_rt = rt; in_use_rs = 1; in_use_rt = 1;
        in_dst = dst; in_reg_wr = 1; in_mem_rd = ld; in_imm = imm; in_ctrl = 16'h5A00 ^ imm[15:0];
    endtask

    // Combinational outputs checked mid-cycle, registered outputs just after each edge
    initial forever begin
        @(negedge clk);
        if (sq.size() > 0) cmp("id_stall_rf_addr", 160'({id_stall, rf_addr1, rf_addr2}), 160'(sq.pop_front()));
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (oq.size() > 0) cmp("id_ex_reg", 160'(dut_state()), 160'(oq.pop_front()));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        idle();
        m = '0;
        #1;
        cmp("reset_state", 160'(dut_state()), 160'(0));
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #2;

        // WB bypass covers the same-edge register-file write
        idle(); instr(5, 0, 2, 0, 32'h11);
        wb_wr = 1; wb_dst = 5; wb_data = 32'hA5A5_0001;
        step();
        cmp("wb_bypass", 160'(out_a), 160'(32'hA5A5_0001));

        // EX beats MEM for the same register
        idle(); instr(1, 2, 3, 0, 32'h22); step();
        idle(); instr(0, 3, 4, 0, 32'h33);
        ex_result = 32'd7; mem_wr = 1; mem_dst = 3; mem_data = 32'd9; rf_data2 = 32'd1;
        step();
        cmp("ex_over_mem", 160'(out_b), 160'(32'd7));

        // $0 never forwards
        idle(); instr(0, 0, 6, 0, 32'h44);
        mem_wr = 1; mem_dst = 0; mem_data = 32'hFFFF_FFFF; rf_data1 = 32'h1234;
        step();
        cmp("zero_reg", 160'(out_a), 160'(0));

        // Load-use: one bubble, then the load's data via MEM
        idle(); instr(0, 0, 8, 1, 32'h55); step();
        idle(); instr(8, 0, 9, 0, 32'h66); rf_data1 = 32'h111;
        #1 cmp("lu_stall", 160'(id_stall), 160'(1));
        step();
        cmp("lu_bubble", 160'({out_valid, stall_cnt}), 160'({1'b0, 16'd1}));
        mem_wr = 1; mem_dst = 8; mem_data = 32'hCAFE_0008;
        #1 cmp("lu_release", 160'(id_stall), 160'(0));
        step();
        cmp("lu_mem_data", 160'(out_a), 160'(32'hCAFE_0008));

        // ex_hold freezes everything and overrides flush
        idle(); instr(0, 0, 4, 0, 32'd77); step();
        for (int c = 0; c < 3; c++) begin
            idle(); instr(1, 1, 5, 0, 32'h99);
            ex_hold = 1; flush = (c == 1);
            #1 cmp("hold_stall", 160'(id_stall), 160'(1));
            step();
            cmp("hold_frozen", 160'({out_valid, out_imm, out_dst}), 160'({1'b1, 32'd77, 5'd4}));
        end
        idle(); instr(1, 1, 5, 0, 32'h99); flush = 1; step();
        cmp("flush_bubble", 160'({out_valid, out_reg_wr, out_mem_rd}), 160'(0));

        // Async reset in the middle of a load-use stall
        idle(); instr(0, 0, 6, 1, 32'h77); step();
        idle(); instr(6, 0, 7, 0, 32'h88);
        #1 cmp("pre_reset_stall", 160'(id_stall), 160'(1));
        reset = 1'b0;
        #1;
        m = '0;
        cmp("async_reset", 160'(dut_state()), 160'(0));
        cmp("reset_drops_stall", 160'(id_stall), 160'(0));
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #2;

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            in_rs     = 5'($urandom_range(0, 3));
            in_rt     = 5'($urandom_range(0, 3));
            in_use_rs = $urandom_range(0, 1);
            in_use_rt = $urandom_range(0, 1);
            in_dst    = 5'($urandom_range(0, 3));
            in_reg_wr = $urandom_range(0, 1);
            in_mem_rd = ($urandom_range(0, 9) < 3);
            in_imm    = $urandom;
            in_ctrl   = 16'($urandom);
            rf_data1  = $urandom;
            rf_data2  = $urandom;
            ex_result = $urandom;
            mem_wr    = $urandom_range(0, 1);
            mem_dst   = 5'($urandom_range(0, 3));
            mem_data  = $urandom;
            wb_wr     = $urandom_range(0, 1);
            wb_dst    = 5'($urandom_range(0, 3));
            wb_data   = $urandom;
            flush     = ($urandom_range(0, 9) == 0);
            ex_hold   = ($urandom_range(0, 9) == 0);
            step();
        end

        idle();
        repeat (2) @(posedge clk);
        if (oq.size() != 0 || sq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", oq.size(), sq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
